// File: rtl/pipeline_skid_chain.sv
// pipeline_skid_chain: DEPTH valid/ready skid stages in series.
// Each stage holds a main entry (visible downstream) and a skid entry that
// absorbs the beat arriving while the stage is stalled, so every ready
// signal comes straight from a register and no combinational ready path
// crosses the chain. Capacity is 2*DEPTH beats; occupancy tracks the number
// of beats held.
// Optional feature macro: PIPE_SKID_FLUSH_EN adds a synchronous flush input
// that blocks both handshakes for the cycle and clears every valid bit.
module pipeline_skid_chain #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [$clog2(2*DEPTH+1)-1:0]     occupancy
`ifdef PIPE_SKID_FLUSH_EN
  ,
  input  logic                             flush
`endif
);

  localparam int OCC_W = $clog2(2*DEPTH+1);

  logic [DEPTH-1:0]      main_valid;
  logic [DEPTH-1:0]      skid_valid;
  logic [DEPTH-1:0]      up_valid;
  logic [DEPTH-1:0]      dn_ready;
  logic [DATA_WIDTH-1:0] main_data [DEPTH];
  logic [DATA_WIDTH-1:0] up_data   [DEPTH];
  logic                  in_xfer;
  logic                  out_xfer;

  // Edge handshakes of the whole chain; flush masks both sides for its cycle.
`ifdef PIPE_SKID_FLUSH_EN
  assign in_ready              = !skid_valid[0] && !flush;
  assign out_valid             = main_valid[DEPTH-1] && !flush;
  assign up_valid[0]           = in_valid && !flush;
  assign dn_ready[DEPTH-1]     = out_ready && !flush;
`else
  assign in_ready              = !skid_valid[0];
  assign out_valid             = main_valid[DEPTH-1];
  assign up_valid[0]           = in_valid;
  assign dn_ready[DEPTH-1]     = out_ready;
`endif
  assign up_data[0] = in_data;
  assign out_data   = main_data[DEPTH-1];
  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = out_valid && out_ready;

  // Stage-to-stage wiring: stage i feeds from stage i-1's main entry and
  // sees the registered skid state of stage i+1 as its downstream ready.
  for (genvar i = 0; i < DEPTH; i++) begin : g_link
    if (i > 0) begin : g_up
      assign up_valid[i] = main_valid[i-1];
      assign up_data[i]  = main_data[i-1];
    end
    if (i < DEPTH-1) begin : g_dn
      assign dn_ready[i] = !skid_valid[i+1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic                  m_v;
    logic                  s_v;
    logic [DATA_WIDTH-1:0] m_d;
    logic [DATA_WIDTH-1:0] s_d;
    logic                  up_xfer;
    logic                  dn_xfer;

    assign up_xfer = up_valid[i] && !s_v;
    assign dn_xfer = m_v && dn_ready[i];

    // Skid stage: refill main from skid first, then from upstream; the skid
    // entry only loads while empty, which the registered ready guarantees.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_v <= 1'b0;
        s_v <= 1'b0;
        m_d <= '0;
        s_d <= '0;
      end
`ifdef PIPE_SKID_FLUSH_EN
      else if (flush) begin
        m_v <= 1'b0;
        s_v <= 1'b0;
      end
`endif
      else begin
        if (!m_v || dn_xfer) begin
          if (s_v) begin
            m_d <= s_d;
            m_v <= 1'b1;
            s_v <= 1'b0;
          end else if (up_xfer) begin
            m_d <= up_data[i];
            m_v <= 1'b1;
          end else begin
            m_v <= 1'b0;
          end
        end else if (up_xfer) begin
          s_d <= up_data[i];
          s_v <= 1'b1;
        end
      end
    end

    assign main_valid[i] = m_v;
    assign skid_valid[i] = s_v;
    assign main_data[i]  = m_d;
  end

  // Occupancy: one step per edge handshake, net zero when both happen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end
`ifdef PIPE_SKID_FLUSH_EN
    else if (flush) begin
      occupancy <= '0;
    end
`endif
    else begin
      if (in_xfer && !out_xfer) begin
        occupancy <= occupancy + OCC_W'(1);
      end else if (out_xfer && !in_xfer) begin
        occupancy <= occupancy - OCC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_skid_chain.sv
// Testbench for pipeline_skid_chain: directed scenarios on a DEPTH=2 chain
// plus concurrent random valid/ready traffic on DEPTH=1, 3 and 4 chains.
module tb_pipeline_skid_chain;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  occupancy;
`ifdef PIPE_SKID_FLUSH_EN
  logic        flush;
`endif

  logic [2:0]  riv;
  logic [2:0]  rir;
  logic [2:0]  rov;
  logic [2:0]  ror;
  logic [31:0] rid [3];
  logic [31:0] rod [3];
  logic [1:0]  occ1;
  logic [2:0]  occ3;
  logic [3:0]  occ4;

  int n_tests;
  int n_fail;

  logic [31:0] fv [5];

  pipeline_skid_chain #(.DATA_WIDTH(32), .DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_SKID_FLUSH_EN
    , .flush(flush)
`endif
  );

  pipeline_skid_chain #(.DATA_WIDTH(32), .DEPTH(1)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(riv[0]), .in_ready(rir[0]), .in_data(rid[0]),
    .out_valid(rov[0]), .out_ready(ror[0]), .out_data(rod[0]),
    .occupancy(occ1)
`ifdef PIPE_SKID_FLUSH_EN
    , .flush(1'b0)
`endif
  );

  pipeline_skid_chain #(.DATA_WIDTH(32), .DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(riv[1]), .in_ready(rir[1]), .in_data(rid[1]),
    .out_valid(rov[1]), .out_ready(ror[1]), .out_data(rod[1]),
    .occupancy(occ3)
`ifdef PIPE_SKID_FLUSH_EN
    , .flush(1'b0)
`endif
  );

  pipeline_skid_chain #(.DATA_WIDTH(32), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(riv[2]), .in_ready(rir[2]), .in_data(rid[2]),
    .out_valid(rov[2]), .out_ready(ror[2]), .out_data(rod[2]),
    .occupancy(occ4)
`ifdef PIPE_SKID_FLUSH_EN
    , .flush(1'b0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int lane_occ(int l);
    if (l == 0) return int'(occ1);
    if (l == 1) return int'(occ3);
    return int'(occ4);
  endfunction

  function automatic logic [31:0] lane_word(int l, int s);
    return (32'(l) << 24) | 32'(s);
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 3'd0 || out_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b occ=%0d out_data=%h, required 0 1 0 0",
               out_valid, in_ready, occupancy, out_data);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    int exp_occ;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      in_valid = (c < 16);
      in_data  = 32'(c);
      @(negedge clk);
      if (c < 16) begin
        n_tests++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_in_ready c=%0d: got %b, required 1", c, in_ready);
        end
      end
      n_tests++;
      if (out_valid !== (c >= 2 && c < 18)) begin
        n_fail++;
        $display("FAIL stream_out_valid c=%0d: got %b, required %b", c, out_valid, (c >= 2 && c < 18));
      end else if (out_valid && out_data !== 32'(c - 2)) begin
        n_fail++;
        $display("FAIL stream_out_data c=%0d: got %h, required %h", c, out_data, 32'(c - 2));
      end
      exp_occ = ((c < 16) ? c : 16) - ((c < 2) ? 0 : ((c - 2 > 16) ? 16 : c - 2));
      n_tests++;
      if (int'(occupancy) != exp_occ) begin
        n_fail++;
        $display("FAIL stream_occ c=%0d: got %0d, required %0d", c, occupancy, exp_occ);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_fill();
    int acc;
    acc = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = fv[(acc < 5) ? acc : 4];
      @(negedge clk);
      if (in_ready) acc++;
      if (c >= 2) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== fv[0]) begin
          n_fail++;
          $display("FAIL fill_hold c=%0d: out_valid=%b out_data=%h, required 1 %h", c, out_valid, out_data, fv[0]);
        end
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (acc != 4) begin
      n_fail++;
      $display("FAIL fill_accepted: got %0d, required 4", acc);
    end
    n_tests++;
    if (in_ready !== 1'b0 || occupancy !== 3'd4) begin
      n_fail++;
      $display("FAIL fill_full: in_ready=%b occ=%0d, required 0 4", in_ready, occupancy);
    end
  endtask

  task automatic test_drain();
    int n;
    n = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_tests++;
      if (int'(occupancy) != 4 - n) begin
        n_fail++;
        $display("FAIL drain_occ c=%0d: got %0d, required %0d", c, occupancy, 4 - n);
      end
      if (out_valid) begin
        n_tests++;
        if (n >= 4) begin
          n_fail++;
          $display("FAIL drain_extra: beat %h, required none", out_data);
        end else if (out_data !== fv[n]) begin
          n_fail++;
          $display("FAIL drain_data n=%0d: got %h, required %h", n, out_data, fv[n]);
        end
        n++;
      end
    end
    n_tests++;
    if (n != 4 || in_ready !== 1'b1 || occupancy !== 3'd0) begin
      n_fail++;
      $display("FAIL drain_end: beats=%0d in_ready=%b occ=%0d, required 4 1 0", n, in_ready, occupancy);
    end
  endtask

  task automatic push3();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 32'hC0 + 32'(k);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (occupancy !== 3'd3) begin
      n_fail++;
      $display("FAIL held3_occ: got %0d, required 3", occupancy);
    end
  endtask

  task automatic test_mid_reset();
    push3();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 3'd0) begin
      n_fail++;
      $display("FAIL midreset_state: out_valid=%b in_ready=%b occ=%0d, required 0 1 0",
               out_valid, in_ready, occupancy);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
        n_fail++;
        $display("FAIL midreset_stale c=%0d: out_valid=%b occ=%0d, required 0 0", c, out_valid, occupancy);
      end
    end
  endtask

`ifdef PIPE_SKID_FLUSH_EN
  task automatic test_flush();
    bit seen;
    push3();
    @(posedge clk); #1;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h77;
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_gate: in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    flush   = 1'b0;
    in_data = 32'h99;
    @(negedge clk);
    n_tests++;
    if (occupancy !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_clear: occ=%0d out_valid=%b in_ready=%b, required 0 0 1",
               occupancy, out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        n_tests++;
        if (out_data !== 32'h99) begin
          n_fail++;
          $display("FAIL flush_first_out: got %h, required 00000099", out_data);
        end
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL flush_first_out: no beat within 6 clks, required 00000099");
    end
  endtask
`endif

  task automatic test_random();
    localparam int NB = 3000;
    int   s [3];
    int   r [3];
    bit   stall [3];
    logic [31:0] prev_d [3];
    int   cyc;
    bit   done;
    for (int l = 0; l < 3; l++) begin
      s[l] = 0; r[l] = 0; stall[l] = 1'b0; prev_d[l] = '0;
    end
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 40000) begin
      @(posedge clk); #1;
      for (int l = 0; l < 3; l++) begin
        riv[l] = ($urandom_range(0, 1) == 1) && (s[l] < NB);
        rid[l] = lane_word(l, s[l]);
        ror[l] = ($urandom_range(0, 1) == 1);
      end
      @(negedge clk);
      for (int l = 0; l < 3; l++) begin
        n_tests++;
        if (lane_occ(l) != s[l] - r[l]) begin
          n_fail++;
          $display("FAIL rand_occ lane=%0d cyc=%0d: got %0d, required %0d", l, cyc, lane_occ(l), s[l] - r[l]);
        end
        if (stall[l]) begin
          n_tests++;
          if (rov[l] !== 1'b1 || rod[l] !== prev_d[l]) begin
            n_fail++;
            $display("FAIL rand_hold lane=%0d cyc=%0d: out_valid=%b out_data=%h, required 1 %h",
                     l, cyc, rov[l], rod[l], prev_d[l]);
          end
        end
        if (rov[l]) begin
          n_tests++;
          if (rod[l] !== lane_word(l, r[l])) begin
            n_fail++;
            $display("FAIL rand_order lane=%0d cyc=%0d: got %h, required %h", l, cyc, rod[l], lane_word(l, r[l]));
          end
        end
        if (riv[l] && rir[l]) s[l]++;
        if (rov[l] && ror[l]) r[l]++;
        stall[l]  = rov[l] && !ror[l];
        prev_d[l] = rod[l];
      end
      cyc++;
      done = (r[0] >= NB) && (r[1] >= NB) && (r[2] >= NB);
    end
    riv = '0;
    ror = '0;
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL rand_complete: received %0d/%0d/%0d, required %0d each", r[0], r[1], r[2], NB);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    fv[0] = 32'hAAAA5555;
    fv[1] = 32'h12345678;
    fv[2] = 32'hDEADBEEF;
    fv[3] = 32'h0F0F0F0F;
    fv[4] = 32'h55555555;
    riv = '0;
    ror = '0;
    for (int l = 0; l < 3; l++) rid[l] = '0;
`ifdef PIPE_SKID_FLUSH_EN
    flush = 1'b0;
`endif
    test_reset();
    test_stream();
    test_fill();
    test_drain();
    test_mid_reset();
`ifdef PIPE_SKID_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
